// File: rtl/pc_gen_unit.sv
// Program-counter generator for the IF stage.
// Provides a registered PC with stall hold, EX-stage redirect and trap redirect,
// a one-cycle fetch bubble with a flush pulse after every accepted redirect,
// and a saturating redirect counter.
// Optional macro PC_ALIGN_CHECK_EN: forces redirect targets to STEP alignment
// and adds the align_err pulse output.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     STEP         = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int unsigned     CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
`ifdef PC_ALIGN_CHECK_EN
    output logic             align_err,
`endif
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus,
    output logic             fetch_valid,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StBubble
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              take_redirect;
    logic [XLEN-1:0]   raw_target;
    logic [XLEN-1:0]   target;

`ifdef PC_ALIGN_CHECK_EN
    // STEP is a power of two, so STEP-1 covers exactly the low log2(STEP) bits.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP_W - XLEN'(1));

    logic align_err_q, align_err_d;
    logic misaligned;
`endif

    // Select the redirect source; traps win over EX-stage redirects.
    always_comb begin
        take_redirect = (state_q != StBoot) && (trap_valid || redirect_valid);
        raw_target    = trap_valid ? trap_vector : redirect_target;
`ifdef PC_ALIGN_CHECK_EN
        target        = raw_target & ALIGN_MASK;
        misaligned    = |(raw_target & ~ALIGN_MASK);
`else
        target        = raw_target;
`endif
    end

    // Next-state logic for the boot / run / bubble sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        cnt_d         = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
        align_err_d   = 1'b0;
`endif
        case (state_q)
            StBoot: begin
                state_d       = StRun;
                fetch_valid_d = 1'b1;
            end
            StRun, StBubble: begin
                if (take_redirect) begin
                    // A same-cycle stall is dropped: the stalled instruction is flushed.
                    state_d       = StBubble;
                    pc_d          = target;
                    fetch_valid_d = 1'b0;
                    flush_d       = 1'b1;
                    cnt_d         = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PC_ALIGN_CHECK_EN
                    align_err_d   = misaligned;
`endif
                end else if (state_q == StBubble) begin
                    // Target was fetched during the bubble; it is valid from now on.
                    state_d       = StRun;
                    fetch_valid_d = 1'b1;
                end else if (!stall) begin
                    pc_d          = pc_plus;
                    fetch_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            cnt_q         <= '0;
`ifdef PC_ALIGN_CHECK_EN
            align_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
`ifdef PC_ALIGN_CHECK_EN
            align_err_q   <= align_err_d;
`endif
        end
    end

    // Output drive; pc_plus wraps modulo 2^XLEN.
    always_comb begin
        pc             = pc_q;
        pc_plus        = pc_q + STEP_W;
        fetch_valid    = fetch_valid_q;
        flush          = flush_q;
        redirect_count = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
        align_err      = align_err_q;
`endif
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios followed by random stimulus, all
// compared against a cycle-level behavioural model. A second instance with a
// 2-bit counter covers counter saturation.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = 32'h0;

    logic [31:0] pc, pc_plus, pc_s, pc_plus_s;
    logic        fetch_valid, flush, fetch_valid_s, flush_s;
    logic [15:0] redirect_count;
    logic [1:0]  redirect_count_s;
`ifdef PC_ALIGN_CHECK_EN
    logic        align_err, align_err_s;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = boot, 1 = run, 2 = bubble.
    logic [31:0] m_pc;
    logic        m_fv, m_fl, m_ae;
    int          m_cnt;
    int          m_mode;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
`ifdef PC_ALIGN_CHECK_EN
        .align_err       (align_err),
`endif
        .pc              (pc),
        .pc_plus         (pc_plus),
        .fetch_valid     (fetch_valid),
        .flush           (flush),
        .redirect_count  (redirect_count)
    );

    pc_gen_unit #(.CNT_W(2)) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
`ifdef PC_ALIGN_CHECK_EN
        .align_err       (align_err_s),
`endif
        .pc              (pc_s),
        .pc_plus         (pc_plus_s),
        .fetch_valid     (fetch_valid_s),
        .flush           (flush_s),
        .redirect_count  (redirect_count_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_fv   = 1'b0;
        m_fl   = 1'b0;
        m_ae   = 1'b0;
        m_cnt  = 0;
        m_mode = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] raw;
        m_ae = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
            m_fv   = 1'b1;
            m_fl   = 1'b0;
        end else if (trap_valid || redirect_valid) begin
            raw = trap_valid ? trap_vector : redirect_target;
`ifdef PC_ALIGN_CHECK_EN
            m_pc = {raw[31:2], 2'b00};
            m_ae = (raw[1:0] != 2'b00);
`else
            m_pc = raw;
`endif
            m_fl   = 1'b1;
            m_fv   = 1'b0;
            m_cnt  = m_cnt + 1;
            m_mode = 2;
        end else if (m_mode == 2) begin
            m_mode = 1;
            m_fv   = 1'b1;
            m_fl   = 1'b0;
        end else if (stall) begin
            m_fl = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
            m_fv = 1'b1;
            m_fl = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("pc_plus", 64'(pc_plus), 64'(32'(m_pc + 32'd4)));
        chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
        chk("flush", 64'(flush), 64'(m_fl));
        chk("redirect_count", 64'(redirect_count), 64'(m_cnt > 65535 ? 65535 : m_cnt));
        chk("sat_count", 64'(redirect_count_s), 64'(m_cnt > 3 ? 3 : m_cnt));
        chk("sat_pc", 64'(pc_s), 64'(m_pc));
`ifdef PC_ALIGN_CHECK_EN
        chk("align_err", 64'(align_err), 64'(m_ae));
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset held for three edges, then the BOOT cycle.
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst = 1'b0;
        #1;
        check_all();

        // Sequential fetch up to 0x10, then a 3-cycle stall.
        for (int i = 0; i < 20 && m_pc != 32'h10; i++) step();
        chk("reach_0x10", 64'(pc), 64'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        step();
        chk("after_stall", 64'(pc), 64'h14);

        // Single redirect to 0x100 at pc=0x20.
        for (int i = 0; i < 20 && m_pc != 32'h20; i++) step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        chk("redir_flush", 64'(flush), 64'h1);
        redirect_valid = 1'b0;
        step();
        step();
        chk("redir_next", 64'(pc), 64'h104);
        chk("redir_count", 64'(redirect_count), 64'h1);

        // Trap beats redirect and stall; then a redirect during the bubble.
        trap_valid      = 1'b1;
        trap_vector     = 32'h80;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        stall           = 1'b1;
        step();
        chk("trap_prio", 64'(pc), 64'h80);
        trap_valid      = 1'b0;
        stall           = 1'b0;
        redirect_target = 32'h300;
        step();
        chk("bubble_redir", 64'(pc), 64'h300);
        redirect_valid = 1'b0;
        step();
        step();

        // Wrap-around past the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("wrap", 64'(pc), 64'h0);

        // Fifth redirect: the 2-bit counter must stay at 3.
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        chk("sat_stop", 64'(redirect_count_s), 64'h3);

        // Asynchronous reset in the middle of a bubble.
        redirect_valid  = 1'b1;
        redirect_target = 32'h400;
        step();
        redirect_valid = 1'b0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        #1;
        check_all();
        step();
        step();

        // Misaligned target: masked only when alignment checking is built in.
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0;
        step();
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stall           = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 5) == 0);
            trap_valid      = ($urandom_range(0, 11) == 0);
            redirect_target = $urandom;
            trap_vector     = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
